inst_loader: RTL and testbench
==============================

# inst_loader

Board-side program loader that writes the instruction memory. It is the writer on the instruction-memory port that the single-cycle CPU reads from. While loader mode is enabled, an operator sets a byte on the switches and presses the load button; four presses assemble one 32-bit instruction, most-significant byte first, which is then written to the next word-aligned address. The CPU is held in reset by the top level while `enable` is high.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles needed before the debounced button level changes. Board builds use about 1_000_000.
- `ADDR_WIDTH`, default 8: width of the byte address. The address space is 2^ADDR_WIDTH bytes, so 64 words at the default.

Ports:
- `clock_in`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: loader mode. Level input, synchronous to `clock_in`.
- `btn_load`, in, 1: raw push button, active-high. Asynchronous and bouncy.
- `byte_in`, in, 8: switch byte. Sampled on the press event.
- `mem_we`, out, 1: instruction-memory write strobe. One-cycle pulse.
- `mem_addr`, out, ADDR_WIDTH: byte address of the write. Always a multiple of 4.
- `mem_wdata`, out, 32: the assembled instruction.
- `byte_idx`, out, 2: number of bytes already collected for the current word.
- `words_loaded`, out, ADDR_WIDTH-2: count of words written since `enable` rose. Wraps.
- `wrapped`, out, 1: sticky flag. Set when `mem_addr` wraps past the top of memory.

## Operation
Button conditioning:
- Two-flop synchronizer on `btn_load`.
- Debounce counter: the debounced level takes the synchronized value only after that value has differed from the current debounced level for `DEBOUNCE_CYCLES` consecutive cycles. Any return to the old value clears the counter.
- `press_evt` is a registered one-cycle pulse on each 0→1 transition of the debounced level. Releases produce no event.

State machine (states IDLE, COLLECT, WRITE):
- **IDLE:**
  - `enable`=0.
  - `mem_addr`, `byte_idx`, `words_loaded` and `wrapped` are held at 0. The shift register is cleared.
  - On `enable`=1, go to COLLECT.
- **COLLECT:**
  - On `press_evt`: shift register ← {shift[23:0], `byte_in`} and `byte_idx` ← `byte_idx`+1.
  - If `byte_idx` was 3, `byte_idx` ← 0 and go to WRITE.
- **WRITE:**
  - `mem_we`=1 for exactly this cycle. `mem_wdata` equals the shift register; `mem_addr` equals the current address.
  - Next cycle: `mem_addr` ← `mem_addr`+4 (modulo 2^ADDR_WIDTH), `words_loaded`+1, and go to COLLECT.
  - If `mem_addr` was 2^ADDR_WIDTH−4, it wraps to 0 and `wrapped` ← 1.
- **`enable`=0 in any state:**
  - Go to IDLE on the next edge.
  - A partially collected word is discarded.
  - If WRITE is the current cycle, that write still completes; the deassertion takes effect after it.

Invariants:
- `mem_wdata` holds its last written value whenever `mem_we`=0. It is cleared only by reset.
- `press_evt` is ignored in IDLE and in WRITE. It cannot occur in WRITE under debounce, but the RTL must still ignore it there.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `byte_idx`=0, `words_loaded`=0, `wrapped`=0. State is IDLE and the debounced level is 0.
- Asynchronous assertion of `reset` takes effect immediately, including mid-word and mid-WRITE. The pending write is lost.
- Button latency: `press_evt` follows a clean raw rising edge by 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 cycles.
- `byte_idx` updates on the edge after `press_evt`.
- `mem_we` is high in the cycle immediately after the fourth `press_evt` has been registered. It is high for exactly 1 cycle.
- `mem_addr` and `words_loaded` advance on the edge that ends WRITE.
- Memory capture: instruction memory samples on the `clock_in` edge that ends WRITE.
- Throughput: at most one byte per debounced press, so at least 2·`DEBOUNCE_CYCLES` cycles between bytes.

## Test plan
- **Reset:** drive `reset`=0 with the button bouncing.
  - All outputs must be 0; no `mem_we`.
  - After release with `enable`=0, the outputs must stay 0.
- **Single word:**
  - Set `enable`=1, then four clean presses with `byte_in` = 0x20, 0x08, 0x00, 0x05.
  - Expect exactly one `mem_we` pulse with `mem_addr`=0x00 and `mem_wdata`=0x20080005.
  - Afterwards `mem_addr`=0x04, `words_loaded`=1, `byte_idx`=0.
- **Bounce rejection:**
  - Pulses shorter than `DEBOUNCE_CYCLES` (e.g. 10 toggles of 3 cycles each) must produce no `byte_idx` change.
  - A press held for `DEBOUNCE_CYCLES`+5 cycles must produce exactly one increment, even if it is followed by release bounce.
- **Wrap:**
  - With `ADDR_WIDTH`=4, load 5 words.
  - Writes must go to 0x0, 0x4, 0x8, 0xC, then 0x0.
  - `wrapped`=1 from the fifth WRITE onward.
- **Abort:**
  - After 2 bytes, drop `enable` for 1 cycle and then raise it again.
  - Expect `byte_idx`=0, `mem_addr`=0, no `mem_we`.
  - The next 4 bytes form a fresh word at 0x00.
- **Async reset mid-WRITE:**
  - Assert `reset` in the WRITE cycle.
  - `mem_we` must drop immediately and `mem_addr`/`words_loaded` must be 0.

Source files
------------

// File: rtl/inst_loader.sv
// Program loader: assembles four debounced switch bytes (MSB first) into one
// 32-bit instruction and writes it to the next word address of instruction memory.
module inst_loader #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                  i_clock_in,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_btn_load,
    input  logic [7:0]            i_byte_in,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic [1:0]            o_byte_idx,
    output logic [ADDR_WIDTH-3:0] o_words_loaded,
    output logic                  o_wrapped
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      DB_LAST        = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic                  r_sync1;
    logic                  r_sync2;
    logic [CNT_W-1:0]      r_db_cnt;
    logic                  r_db_level;
    logic                  r_db_prev;
    logic                  r_press_evt;

    logic [1:0]            r_state;
    logic [23:0]           r_shift;
    logic [31:0]           r_wdata;
    logic [1:0]            r_byte_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-3:0] r_words;
    logic                  r_wrapped;

    logic [31:0]           w_shift_next;

    // Button conditioning: synchronize, debounce, then edge-detect the clean level.
    always_ff @(posedge i_clock_in or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_db_cnt    <= '0;
            r_db_level  <= 1'b0;
            r_db_prev   <= 1'b0;
            r_press_evt <= 1'b0;
        end else begin
            r_sync1   <= i_btn_load;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
            r_press_evt <= r_db_level & ~r_db_prev;
        end
    end

    assign w_shift_next = {r_shift, i_byte_in};

    always_ff @(posedge i_clock_in or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_wdata    <= '0;
            r_byte_idx <= '0;
            r_addr     <= '0;
            r_words    <= '0;
            r_wrapped  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_shift    <= '0;
                    r_byte_idx <= '0;
                    r_addr     <= '0;
                    r_words    <= '0;
                    r_wrapped  <= 1'b0;
                    if (i_enable) begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!i_enable) begin
                        r_state <= ST_IDLE;
                    end else if (r_press_evt) begin
                        r_shift <= w_shift_next[23:0];
                        if (r_byte_idx == 2'd3) begin
                            // wdata is a separate register so it survives the IDLE clear.
                            r_wdata    <= w_shift_next;
                            r_byte_idx <= 2'd0;
                            r_state    <= ST_WRITE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_addr  <= r_addr + ADDR_WIDTH'(4);
                    r_words <= r_words + 1'b1;
                    if (r_addr == LAST_WORD_ADDR) begin
                        r_wrapped <= 1'b1;
                    end
                    r_state <= i_enable ? ST_COLLECT : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_we       = (r_state == ST_WRITE);
    assign o_mem_addr     = r_addr;
    assign o_mem_wdata    = r_wdata;
    assign o_byte_idx     = r_byte_idx;
    assign o_words_loaded = r_words;
    assign o_wrapped      = r_wrapped;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: stimulus queues expected writes, a negedge
// monitor pops and compares them whenever mem_we is seen.
module tb_inst_loader;

    localparam int DB = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          btn;
    logic [7:0]    byte_in;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [1:0]    byte_idx;
    logic [AW-3:0] words_loaded;
    logic          wrapped;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          wrap;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    inst_loader #(.DEBOUNCE_CYCLES(DB), .ADDR_WIDTH(AW)) dut (
        .i_clock_in    (clk),
        .i_reset       (rst_n),
        .i_enable      (enable),
        .i_btn_load    (btn),
        .i_byte_in     (byte_in),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_byte_idx    (byte_idx),
        .o_words_loaded(words_loaded),
        .o_wrapped     (wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every mem_we cycle must match the oldest queued write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            wr_t e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_we: got write addr=0x%0h data=0x%08h, expected none", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || wrapped !== e.wrap) begin
                    n_fail++;
                    $display("FAIL write: got addr=0x%0h data=0x%08h wrapped=%0b, expected addr=0x%0h data=0x%08h wrapped=%0b",
                             mem_addr, mem_wdata, wrapped, e.addr, e.data, e.wrap);
                end else begin
                    $display("[TB] write addr=0x%0h data=0x%08h wrapped=%0b", mem_addr, mem_wdata, wrapped);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [7:0] b);
        byte_in = b;
        btn     = 1'b1;
        tick(DB + 8);
        btn     = 1'b0;
        tick(DB + 8);
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d, input logic w);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.wrap = w;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        btn     = 1'b0;
        byte_in = 8'h00;

        // Reset held while the button bounces.
        for (int i = 0; i < 20; i++) begin
            btn = ~btn;
            tick(2);
        end
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {28'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_byte_idx", {30'd0, byte_idx}, 32'd0);
        check("rst_words", {30'd0, words_loaded}, 32'd0);
        check("rst_wrapped", {31'd0, wrapped}, 32'd0);

        // Released with enable low: presses must do nothing.
        rst_n = 1'b1;
        btn   = 1'b0;
        press(8'hFF);
        check("idle_byte_idx", {30'd0, byte_idx}, 32'd0);
        check("idle_addr", {28'd0, mem_addr}, 32'd0);

        // Single word.
        enable = 1'b1;
        tick(2);
        expect_write(4'h0, 32'h20080005, 1'b0);
        press(8'h20);
        check("byte_idx_after_1", {30'd0, byte_idx}, 32'd1);
        press(8'h08);
        press(8'h00);
        press(8'h05);
        check("single_addr", {28'd0, mem_addr}, 32'h4);
        check("single_words", {30'd0, words_loaded}, 32'd1);
        check("single_byte_idx", {30'd0, byte_idx}, 32'd0);

        // Short glitches must be rejected.
        byte_in = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            tick(3);
        end
        btn = 1'b0;
        tick(DB + 8);
        check("bounce_reject", {30'd0, byte_idx}, 32'd0);

        // Press held DB+5 cycles, then release bounce: exactly one byte.
        byte_in = 8'h11;
        btn = 1'b1;
        tick(DB + 5);
        for (int i = 0; i < 6; i++) begin
            btn = ~btn;
            tick(2);
        end
        btn = 1'b0;
        tick(DB + 8);
        check("held_press_once", {30'd0, byte_idx}, 32'd1);
        expect_write(4'h4, 32'h11223344, 1'b0);
        press(8'h22);
        press(8'h33);
        press(8'h44);

        // Fill to the top of the 16-byte space and wrap.
        expect_write(4'h8, 32'hAABBCCDD, 1'b0);
        press(8'hAA); press(8'hBB); press(8'hCC); press(8'hDD);
        expect_write(4'hC, 32'h01020304, 1'b0);
        press(8'h01); press(8'h02); press(8'h03); press(8'h04);
        check("wrap_flag_set", {31'd0, wrapped}, 32'd1);
        check("wrap_addr_zero", {28'd0, mem_addr}, 32'h0);
        expect_write(4'h0, 32'hDEADBEEF, 1'b1);
        press(8'hDE); press(8'hAD); press(8'hBE); press(8'hEF);
        check("wrap_addr_after", {28'd0, mem_addr}, 32'h4);
        check("wrap_words", {30'd0, words_loaded}, 32'd1);
        check("wrap_mem_wdata_hold", mem_wdata, 32'hDEADBEEF);

        // Abort mid-word by dropping enable for one cycle.
        press(8'h55);
        press(8'h66);
        check("abort_pre_idx", {30'd0, byte_idx}, 32'd2);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(2);
        check("abort_byte_idx", {30'd0, byte_idx}, 32'd0);
        check("abort_addr", {28'd0, mem_addr}, 32'h0);
        check("abort_wrapped", {31'd0, wrapped}, 32'd0);
        check("abort_words", {30'd0, words_loaded}, 32'd0);
        expect_write(4'h0, 32'h0A0B0C0D, 1'b0);
        press(8'h0A); press(8'h0B); press(8'h0C); press(8'h0D);
        check("fresh_addr", {28'd0, mem_addr}, 32'h4);

        // Async reset during the WRITE cycle: no write is expected.
        press(8'h71); press(8'h72); press(8'h73);
        byte_in = 8'h74;
        btn = 1'b1;
        begin
            int budget = 0;
            while (mem_we !== 1'b1 && budget < 200) begin
                tick(1);
                budget++;
            end
            n_tests++;
            if (mem_we !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_write: got no mem_we within 200 cycles, expected a WRITE cycle");
            end
        end
        rst_n = 1'b0;
        #1;
        check("midwr_we", {31'd0, mem_we}, 32'd0);
        check("midwr_addr", {28'd0, mem_addr}, 32'h0);
        check("midwr_words", {30'd0, words_loaded}, 32'd0);
        check("midwr_wdata", mem_wdata, 32'd0);
        btn = 1'b0;
        tick(3);
        rst_n = 1'b1;
        enable = 1'b0;
        tick(DB + 8);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
